// File: rtl/mult_seq_arbiter.sv
// mult_seq_arbiter: sequencer and round-robin arbiter for a shared shift-add multiplier.
// Ports: clk/rst (sync, active-high), tick step enable, two valid/ready request ports
// (reqN_*), a valid/ready result port (res_*), and status outputs busy/step_count.
// Latency: WIDTH+1 cycles from request handshake to res_valid at full tick rate.
// Backpressure: requests are refused while an op is running or its result is held;
// the product is held until res_ready.
module mult_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         req0_valid,
    input  logic [WIDTH-1:0]             req0_a,
    input  logic [WIDTH-1:0]             req0_b,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [WIDTH-1:0]             req1_a,
    input  logic [WIDTH-1:0]             req1_b,
    output logic                         req1_ready,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [2*WIDTH-1:0]           res_product,
    output logic                         res_id,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   step_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;
    logic                 last_grant;
    logic                 grant;
    logic                 accept;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    // Index of the requester that wins if a handshake happens this cycle.
    // Under contention the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst so a reset cycle can never complete a handshake.
    assign req0_ready = !rst && (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state == S_IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    assign sel_a = grant ? req1_a : req0_a;
    assign sel_b = grant ? req1_b : req0_b;

    assign res_product = acc;
    assign step_count  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand      <= {{WIDTH{1'b0}}, sel_a};
                        mplier     <= sel_b;
                        acc        <= '0;
                        count      <= '0;
                        res_id     <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Fixed WIDTH iterations, even for a zero multiplier.
                    if (tick) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                        if (count == LAST_STEP) begin
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// tb_mult_seq_arbiter: directed scoreboard bench for mult_seq_arbiter.
// Stimulus pushes hand-computed expected products; a monitor checks every result cycle.
// Latency, tick count and step_count tracking are checked per operation.
module tb_mult_seq_arbiter;

    localparam int W = 8;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        res_valid, res_ready, res_id, busy;
    logic [15:0] res_product;
    logic [3:0]  step_count;

    mult_seq_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .res_id(res_id), .busy(busy), .step_count(step_count)
    );

    typedef struct {
        logic [15:0] prod;
        logic        id;
        int          lat;   // expected accept-to-res_valid cycles, 0 = not checked
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   tick_sparse = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out, required event never seen (cycle %0d)", name, cyc);
    endtask

    // Tick generator: every cycle, or one cycle in four.
    initial begin
        tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick = tick_sparse ? (cyc % 4 == 0) : 1'b1;
        end
    end

    // Monitor / scoreboard checker.
    int acc_cyc   = 0;
    int run_ticks = 0;
    bit in_res    = 0;
    bit step_bad  = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_res = 0; run_ticks = 0; step_bad = 0;
                continue;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_cyc = cyc; run_ticks = 0; step_bad = 0;
            end
            if (busy && !res_valid) begin
                if (step_count !== 4'(run_ticks)) step_bad = 1;
                if (tick) run_ticks++;
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got product 0x%0h id %0d, required no result",
                             res_product, res_id);
                end else begin
                    if (!in_res) begin
                        if (sb[0].lat != 0) check("res_latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
                        check("tick_count", 32'(run_ticks), 32'(W));
                        check("step_tracks_ticks", 32'(step_bad), 32'(0));
                        check("step_count_done", 32'(step_count), 32'(W));
                    end
                    check("res_product", 32'(res_product), 32'(sb[0].prod));
                    check("res_id", 32'(res_id), 32'(sb[0].id));
                    if (res_ready) void'(sb.pop_front());
                end
                in_res = !res_ready;
            end else begin
                in_res = 0;
            end
        end
    end

    // Present one request and wait for its handshake; exp_wait = expected negedges until ready.
    task automatic issue(input bit port, input logic [7:0] a, input logic [7:0] b,
                         input bit push, input logic [15:0] prod, input int lat, input int exp_wait);
        int t = 0;
        if (port) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else      begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        do begin
            @(negedge clk);
            t++;
        end while (!(port ? req1_ready : req0_ready) && t < 60);
        if (!(port ? req1_ready : req0_ready)) begin
            timeout_fail("request_accept");
        end else begin
            if (exp_wait != 0) check("accept_wait", 32'(t), 32'(exp_wait));
            if (push) sb.push_back('{prod, port, lat});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            timeout_fail("result_drain");
            sb.delete();
        end
    endtask

    task automatic wait_res();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_valid && t < 100);
        if (!res_valid) timeout_fail("res_valid_wait");
    endtask

    // Both requesters held valid for n grants; expected owner alternates from 'first'.
    task automatic contend(input int n, input bit first,
                           input logic [7:0] a0, input logic [7:0] b0, input logic [15:0] p0,
                           input logic [7:0] a1, input logic [7:0] b1, input logic [15:0] p1);
        bit want = first;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(req0_ready || req1_ready) && t < 60);
            if (!(req0_ready || req1_ready)) begin
                timeout_fail("contention_grant");
            end else begin
                check("single_grant", 32'(req0_ready && req1_ready), 32'(0));
                check("grant_order", 32'(req1_ready), 32'(want));
                sb.push_back('{(req1_ready ? p1 : p0), req1_ready, 9});
            end
            want = ~want;
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_product", 32'(res_product), 32'(0));
        check("rst_res_id", 32'(res_id), 32'(0));
        check("rst_step_count", 32'(step_count), 32'(0));
        check("rst_req0_ready_blocked", 32'(req0_ready), 32'(0));
        check("rst_req1_ready", 32'(req1_ready), 32'(0));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single op with the result held for three cycles.
        res_ready = 1'b0;
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01, 9, 1);
        wait_res();
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_drain();

        // Zero operands still take WIDTH steps.
        issue(1'b0, 8'h00, 8'hA5, 1'b1, 16'h0000, 9, 1);
        wait_drain();
        issue(1'b1, 8'h5A, 8'h00, 1'b1, 16'h0000, 9, 1);
        wait_drain();

        // Contention: req1 was served last, so req0 leads.
        contend(3, 1'b0, 8'd3, 8'd5, 16'd15, 8'd7, 8'd9, 16'd63);

        // Sparse tick: one step per four cycles.
        tick_sparse = 1'b1;
        issue(1'b0, 8'h12, 8'h34, 1'b1, 16'h03A8, 0, 1);
        wait_drain();
        tick_sparse = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a run discards the op.
        issue(1'b0, 8'h55, 8'h66, 1'b0, 16'h0000, 0, 1);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (step_count != 4'd4 && t < 40);
            if (step_count != 4'd4) timeout_fail("step4_wait");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_res_valid", 32'(res_valid), 32'(0));
        check("abort_step_count", 32'(step_count), 32'(0));
        @(posedge clk);
        #1;
        issue(1'b1, 8'h0F, 8'h10, 1'b1, 16'h00F0, 9, 1);
        wait_drain();
        contend(1, 1'b0, 8'd1, 8'd1, 16'd1, 8'd2, 8'd2, 16'd4);

        // Backpressure: no accept while a result is held.
        res_ready = 1'b0;
        issue(1'b0, 8'h02, 8'h03, 1'b1, 16'h0006, 9, 1);
        wait_res();
        @(posedge clk);
        #1;
        req0_a = 8'h04; req0_b = 8'h04; req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req0_ready_low", 32'(req0_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_in_D", 32'(req0_ready), 32'(0));
        @(negedge clk);
        check("bp_ready_in_D1", 32'(req0_ready), 32'(1));
        if (req0_ready) sb.push_back('{16'h0010, 1'b0, 9});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_seq_arbiter.md
# mult_seq_arbiter

Sequencer and two-port arbiter for the 8x8 shift-add multiplier datapath (shift register, bit-select, 16-bit adder, product register). It accepts multiply requests from two requesters over valid/ready handshakes and grants the shared datapath round-robin. It steps the shift-add iterations one per divided-clock enable pulse, then holds the 16-bit product until the consumer takes it. One clock domain: the divided "PWM" rate arrives as a single-cycle enable (`tick`), never as a clock.

## Interface
Parameters:
- `WIDTH`, default 8: operand width. Product is `2*WIDTH`. Step counter is `$clog2(WIDTH+1)` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on its posedge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  step enable from the clock divider. One shift-add iteration per cycle with `tick`=1.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_a`  in  WIDTH  requester 0 multiplicand.
- `req0_b`  in  WIDTH  requester 0 multiplier.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as port 0, for requester 1.
- `res_valid`  out  1  product available.
- `res_ready`  in  1  consumer takes the product.
- `res_product`  out  2*WIDTH  unsigned product.
- `res_id`  out  1  requester index the product belongs to.
- `busy`  out  1  state ≠ IDLE.
- `step_count`  out  $clog2(WIDTH+1)  iterations completed in the current operation.

## Operation
States: IDLE, RUN, DONE.
- **IDLE**
  - `reqN_ready` is combinational: 1 only for the granted requester, only when that requester's valid=1. It is never 1 for both.
  - Grant: one valid → that one. Both valid → the requester not granted last.
  - On handshake (`valid && ready`): latch `mcand={0,a}` (2*WIDTH bits) and `mplier=b`; clear `acc` and `count`; record `res_id`; update `last_grant`; go to RUN.
  - Dropping `reqN_valid` before a grant is legal and leaves no trace.
- **RUN**, each cycle with `tick`=1:
  - If `mplier[0]`: `acc <= acc + mcand`, with a 2*WIDTH-bit add and no overflow possible.
  - `mcand <<= 1`; `mplier >>= 1`; `count++`.
  - When `count` reaches WIDTH, go to DONE.
  - Cycles with `tick`=0 hold all state.
  - Always exactly WIDTH steps; no early exit on a zero multiplier.
- **DONE**:
  - `res_valid`=1. `res_product`=`acc` and `res_id` stay stable until `res_ready`=1.
  - On handshake, go to IDLE.
  - `tick` is ignored.
- `reqN_ready`=0 in RUN and DONE.
- `res_ready` is ignored outside DONE.
- `tick` is ignored in IDLE.

## Timing
- Reset values:
  - state=IDLE; `busy`=0.
  - `reqN_ready`=0 (combinational, no valid → 0).
  - `res_valid`=0, `res_product`=0, `res_id`=0, `step_count`=0.
  - `last_grant`=1, so req0 wins the first contention.
- Reset mid-RUN or mid-DONE: the operation is discarded, no result is emitted, and the next cycle is IDLE.
- Reset has priority over every handshake in the same cycle.
- Latency, handshake in cycle T with `tick`=1 continuously:
  - Steps occur in T+1..T+8.
  - `res_valid` first high in T+9 (WIDTH+1 cycles).
  - Each `tick`=0 cycle during RUN adds one cycle.
- Result handshake in cycle D:
  - IDLE in D+1; the earliest next accept is D+1, giving WIDTH+2 cycles per op at full tick rate.
  - `res_valid` deasserts in D+1.
- `step_count` increments in the cycle after each effective tick and reads WIDTH while in DONE.
- `busy` is registered state decode: 1 from T+1 through D.

## Test plan
- Single op, req0: a=0xFF, b=0xFF, `tick`=1 always → `req0_ready`=1 in T; `res_valid` at T+9; product 0xFE01, `res_id`=0; held 3 cycles with `res_ready`=0, stable.
- Zeros: a=0x00/b=0xA5 and a=0x5A/b=0x00 → product 0x0000, still WIDTH ticks, latency 9.
- Contention: both valid continuously, req0 {3,5}, req1 {7,9} → grant order req0, req1, req0…; products 15 (id 0), 63 (id 1), 15 (id 0).
- Sparse tick, 1 in 4 cycles: a=0x12, b=0x34 → product 0x03A8; `res_valid` after exactly 8 ticks; `step_count` advances only on ticks.
- Reset at step 4 of a RUN, then req1 {0x0F,0x10} → no result from the aborted op; next product 0x00F0, id 1; a subsequent contention is won by req0.
- Backpressure: DONE with `res_ready`=0 for 10 cycles, req0 valid → `req0_ready` stays 0; accept occurs the cycle after the result handshake.
